// File: rtl/crossing_pkg.sv
// Shared widths, state codes and the duration-select rule for the level-crossing sequencer.
package crossing_pkg;

  localparam int TW = 19;
  localparam int SW = 4;

  localparam logic [SW-1:0] S_IDLE   = 4'b0000;
  localparam logic [SW-1:0] S_WARN   = 4'b0001;
  localparam logic [SW-1:0] S_LOWER  = 4'b0010;
  localparam logic [SW-1:0] S_CLOSED = 4'b0011;
  localparam logic [SW-1:0] S_CLEAR  = 4'b0100;
  localparam logic [SW-1:0] S_RAISE  = 4'b0101;
  localparam logic [SW-1:0] S_FAULT  = 4'b1111;

  // Resting/occupied states run on t0; transitional and fault states run on t1.
  function automatic logic [TW-1:0] sel_duration(input logic [SW-1:0] next_state,
                                                 input logic [TW-1:0] t0,
                                                 input logic [TW-1:0] t1);
    logic [TW-1:0] dur;
    case (next_state)
      S_IDLE, S_CLOSED, S_CLEAR: dur = t0;
      default:                   dur = t1;
    endcase
    return dur;
  endfunction

endpackage

// File: rtl/crossing_timer.sv
// Loadable down-counter with saturation at zero, stepped by a prescaled tick strobe.
module crossing_timer
  import crossing_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          tick_en,
  output logic [TW-1:0] count,
  output logic          zero
);

  // A load always wins over a tick on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick_en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/crossing_sequencer.sv
// Moore sequencer for a level crossing: warning, barrier lowering, occupancy, clearance, raising.
module crossing_sequencer
  import crossing_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick_en,
  input  logic [TW-1:0] t0,
  input  logic [TW-1:0] t1,
  input  logic          sensor_in,
  input  logic          sensor_out,
  input  logic          manual_stop,
  input  logic          clear_fault,
  output logic [SW-1:0] present_state,
  output logic          light_yellow,
  output logic          light_red,
  output logic          barrier_down,
  output logic          fault,
  output logic          timer_zero
);

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;
  logic [TW-1:0] timer_count;
  logic          timer_zero_w;
  logic          expire;
  logic          load;

  assign expire = tick_en && (timer_count == '0);
  assign load   = (state_d != state_q);

  crossing_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (sel_duration(state_d, t0, t1)),
    .tick_en  (tick_en),
    .count    (timer_count),
    .zero     (timer_zero_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // manual_stop overrides every state; within a state the listed order is the priority.
  always_comb begin
    state_d = state_q;
    if (manual_stop) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_IDLE:   if (sensor_in) state_d = S_WARN;
        S_WARN:   if (expire) state_d = S_LOWER;
        S_LOWER:  if (expire) state_d = S_CLOSED;
        S_CLOSED: begin
          if (sensor_out)  state_d = S_CLEAR;
          else if (expire) state_d = S_FAULT;
        end
        S_CLEAR: begin
          if (sensor_in)   state_d = S_CLOSED;
          else if (expire) state_d = S_RAISE;
        end
        S_RAISE: begin
          if (sensor_in)   state_d = S_LOWER;
          else if (expire) state_d = S_IDLE;
        end
        S_FAULT:  if (clear_fault && !sensor_in && !sensor_out) state_d = S_IDLE;
        default:  state_d = S_FAULT;
      endcase
    end
  end

  always_comb begin
    light_yellow = 1'b0;
    light_red    = 1'b0;
    barrier_down = 1'b0;
    fault        = 1'b0;
    case (state_q)
      S_WARN, S_RAISE: light_yellow = 1'b1;
      S_LOWER, S_CLOSED, S_CLEAR: begin
        light_red    = 1'b1;
        barrier_down = 1'b1;
      end
      S_FAULT: begin
        light_red    = 1'b1;
        barrier_down = 1'b1;
        fault        = 1'b1;
      end
      default: ;
    endcase
  end

  assign present_state = state_q;
  assign timer_zero    = timer_zero_w;

endmodule

// File: tb/tb_crossing_sequencer.sv
// Directed and randomized bench for crossing_sequencer against a rule-level reference model.
module tb_crossing_sequencer;

  localparam int TW = 19;

  localparam int M_IDLE   = 0;
  localparam int M_WARN   = 1;
  localparam int M_LOWER  = 2;
  localparam int M_CLOSED = 3;
  localparam int M_CLEAR  = 4;
  localparam int M_RAISE  = 5;
  localparam int M_FAULT  = 15;

  logic          clk;
  logic          rst_n;
  logic          tick_en;
  logic [TW-1:0] t0;
  logic [TW-1:0] t1;
  logic          sensor_in;
  logic          sensor_out;
  logic          manual_stop;
  logic          clear_fault;
  logic [3:0]    present_state;
  logic          light_yellow;
  logic          light_red;
  logic          barrier_down;
  logic          fault;
  logic          timer_zero;

  int checks = 0;
  int errors = 0;
  int m_state = M_IDLE;
  int m_timer = 0;

  crossing_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick_en       (tick_en),
    .t0            (t0),
    .t1            (t1),
    .sensor_in     (sensor_in),
    .sensor_out    (sensor_out),
    .manual_stop   (manual_stop),
    .clear_fault   (clear_fault),
    .present_state (present_state),
    .light_yellow  (light_yellow),
    .light_red     (light_red),
    .barrier_down  (barrier_down),
    .fault         (fault),
    .timer_zero    (timer_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: apply the crossing rules to the inputs seen at one rising edge.
  task automatic model_edge();
    bit expire;
    int ns;
    expire = (m_timer == 0) && tick_en;
    ns = m_state;
    if (manual_stop) ns = M_FAULT;
    else begin
      case (m_state)
        M_IDLE:   if (sensor_in) ns = M_WARN;
        M_WARN:   if (expire) ns = M_LOWER;
        M_LOWER:  if (expire) ns = M_CLOSED;
        M_CLOSED: if (sensor_out) ns = M_CLEAR; else if (expire) ns = M_FAULT;
        M_CLEAR:  if (sensor_in) ns = M_CLOSED; else if (expire) ns = M_RAISE;
        M_RAISE:  if (sensor_in) ns = M_LOWER; else if (expire) ns = M_IDLE;
        M_FAULT:  if (clear_fault && !sensor_in && !sensor_out) ns = M_IDLE;
        default:  ns = M_FAULT;
      endcase
    end
    if (ns != m_state)
      m_timer = (ns == M_IDLE || ns == M_CLOSED || ns == M_CLEAR) ? int'(t0) : int'(t1);
    else if (tick_en && m_timer > 0)
      m_timer = m_timer - 1;
    m_state = ns;
  endtask

  task automatic compare_model();
    bit red;
    red = (m_state == M_LOWER || m_state == M_CLOSED || m_state == M_CLEAR || m_state == M_FAULT);
    check("state", 32'(present_state), 32'(m_state));
    check("yellow", 32'(light_yellow), 32'(m_state == M_WARN || m_state == M_RAISE));
    check("red", 32'(light_red), 32'(red));
    check("barrier", 32'(barrier_down), 32'(red));
    check("fault", 32'(fault), 32'(m_state == M_FAULT));
    check("timer_zero", 32'(timer_zero), 32'(m_timer == 0));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic wait_state(input int target, input int exp_n, input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (present_state !== 4'(target) && n < 50);
    check(tag, 32'(n), 32'(exp_n));
  endtask

  task automatic pulse_sensor_in();
    sensor_in = 1'b1;
    step();
    sensor_in = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tick_en = 1'b0; t0 = 19'd3; t1 = 19'd2;
    sensor_in = 1'b0; sensor_out = 1'b0; manual_stop = 1'b0; clear_fault = 1'b0;
    #12;
    check("rst_state", 32'(present_state), 32'd0);
    check("rst_barrier", 32'(barrier_down), 32'd0);
    check("rst_timer_zero", 32'(timer_zero), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal pass: t0=3, t1=2, tick every cycle.
    tick_en = 1'b1;
    pulse_sensor_in();
    check("enter_warn", 32'(present_state), 32'(M_WARN));
    check("warn_yellow", 32'(light_yellow), 32'd1);
    wait_state(M_LOWER, 3, "warn_len");
    check("lower_barrier", 32'(barrier_down), 32'd1);
    wait_state(M_CLOSED, 3, "lower_len");
    sensor_out = 1'b1;
    step();
    sensor_out = 1'b0;
    check("enter_clear", 32'(present_state), 32'(M_CLEAR));
    wait_state(M_RAISE, 4, "clear_len");
    check("raise_yellow", 32'(light_yellow), 32'd1);
    check("raise_red", 32'(light_red), 32'd0);
    wait_state(M_IDLE, 3, "raise_len");

    // Watchdog from CLOSED with t0=5.
    t0 = 19'd5;
    pulse_sensor_in();
    wait_state(M_LOWER, 3, "wd_warn");
    wait_state(M_CLOSED, 3, "wd_lower");
    wait_state(M_FAULT, 6, "watchdog_len");
    check("wd_fault", 32'(fault), 32'd1);
    check("wd_barrier", 32'(barrier_down), 32'd1);
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    check("wd_cleared", 32'(present_state), 32'(M_IDLE));

    // Asynchronous reset in the middle of CLOSED.
    pulse_sensor_in();
    wait_state(M_LOWER, 3, "ar_warn");
    wait_state(M_CLOSED, 3, "ar_lower");
    step();
    #2 rst_n = 1'b0;
    #1;
    m_state = M_IDLE;
    m_timer = 0;
    check("async_state", 32'(present_state), 32'd0);
    check("async_red", 32'(light_red), 32'd0);
    check("async_barrier", 32'(barrier_down), 32'd0);
    check("async_timer_zero", 32'(timer_zero), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Re-entry: RAISE -> LOWER reloads t1; CLEAR -> CLOSED reloads t0.
    t0 = 19'd3;
    pulse_sensor_in();
    wait_state(M_LOWER, 3, "re_warn");
    wait_state(M_CLOSED, 3, "re_lower");
    sensor_out = 1'b1;
    step();
    sensor_out = 1'b0;
    wait_state(M_RAISE, 4, "re_clear");
    sensor_in = 1'b1;
    step();
    sensor_in = 1'b0;
    check("raise_to_lower", 32'(present_state), 32'(M_LOWER));
    wait_state(M_CLOSED, 3, "reload_t1_len");
    sensor_out = 1'b1;
    step();
    sensor_out = 1'b0;
    step();
    sensor_in = 1'b1;
    step();
    sensor_in = 1'b0;
    check("clear_to_closed", 32'(present_state), 32'(M_CLOSED));
    wait_state(M_FAULT, 4, "reload_t0_len");
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;

    // Simultaneous sensor_out and expire in CLOSED; t0=0 expires on first tick.
    t0 = 19'd0;
    pulse_sensor_in();
    wait_state(M_LOWER, 3, "sim_warn");
    wait_state(M_CLOSED, 3, "sim_lower");
    sensor_out = 1'b1;
    step();
    sensor_out = 1'b0;
    check("sensor_out_wins", 32'(present_state), 32'(M_CLEAR));
    step();
    check("zero_dur_expire", 32'(present_state), 32'(M_RAISE));
    wait_state(M_IDLE, 3, "sim_raise");
    t0 = 19'd3;

    // Emergency stop and fault acknowledge rules.
    pulse_sensor_in();
    manual_stop = 1'b1;
    step();
    manual_stop = 1'b0;
    check("manual_stop", 32'(present_state), 32'(M_FAULT));
    clear_fault = 1'b1;
    sensor_in = 1'b1;
    step();
    check("fault_hold", 32'(present_state), 32'(M_FAULT));
    sensor_in = 1'b0;
    step();
    clear_fault = 1'b0;
    check("fault_clear", 32'(present_state), 32'(M_IDLE));

    // Randomized traffic; durations change every cycle to exercise sample-at-load.
    for (int i = 0; i < 3000; i++) begin
      tick_en     = ($urandom_range(0, 3) != 0);
      sensor_in   = ($urandom_range(0, 7) == 0);
      sensor_out  = ($urandom_range(0, 7) == 0);
      manual_stop = ($urandom_range(0, 149) == 0);
      clear_fault = ($urandom_range(0, 3) == 0);
      t0          = 19'($urandom_range(0, 6));
      t1          = 19'($urandom_range(0, 6));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
